// File: rtl/uart_dl.sv
// UART download engine: receives A5/addr/data[/chk] packets, issues one bus write, and replies with a status byte.
// Optional checksum byte and CHK state are enabled by defining UART_DL_CHKSUM_EN.
module uart_dl #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_pin,
  output logic        uart_tx_pin,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  output logic        m_req_o,
  output logic        m_wr_en_o,
  input  logic        m_grant_i,
  output logic        dl_active_o
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {HDR, ADDR, DATA,
`ifdef UART_DL_CHKSUM_EN
    CHK,
`endif
    WRITE, ACK} st_t;

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_st_t        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_vld_q, rx_vld_d;
  logic          tx_busy_q, tx_busy_d, tx_pin_q, tx_pin_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  st_t           st_q, st_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   addr_q, addr_d, data_q, data_d, m_addr_q, m_addr_d, m_data_q, m_data_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] to_q, to_d;
  logic          active_q, active_d, req_q, req_d;
  logic          tx_done, start_ack, go_wr, tmo;
  logic [7:0]    ack_code;

  always_comb begin
    rx_s1_d = uart_rx_pin; rx_s2_d = rx_s1_q; rx_prev_d = rx_s2_q;
    rx_st_d = rx_st_q; rx_cnt_d = rx_cnt_q; rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q; rx_vld_d = 1'b0;
    tx_busy_d = tx_busy_q; tx_pin_d = tx_pin_q; tx_cnt_d = tx_cnt_q; tx_bit_d = tx_bit_q; tx_sh_d = tx_sh_q;
    st_d = st_q; byte_cnt_d = byte_cnt_q; addr_d = addr_q; data_d = data_q; chk_d = chk_q; to_d = to_q;
    active_d = active_q; req_d = req_q; m_addr_d = m_addr_q; m_data_d = m_data_q;
    tx_done = 1'b0; start_ack = 1'b0; go_wr = 1'b0; tmo = 1'b0; ack_code = 8'h00;

    case (rx_st_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin rx_st_d = RX_START; rx_cnt_d = '0; end
      RX_START:
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0; rx_bit_d = '0;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + CW'(1);
      RX_DATA:
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q + CW'(1);
      RX_STOP:
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0; rx_vld_d = rx_s2_q; rx_st_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q + CW'(1);
      default: rx_st_d = RX_IDLE;
    endcase

    // tx_sh holds the remaining frame; pin always shows its LSB
    if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0; tx_done = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          tx_sh_d = {1'b1, tx_sh_q[9:1]};
          tx_pin_d = tx_sh_q[1];
        end
      end else tx_cnt_d = tx_cnt_q + CW'(1);
    end

    case (st_q)
      HDR:
        if (rx_vld_q && rx_sh_q == 8'hA5) begin
          st_d = ADDR; active_d = 1'b1; byte_cnt_d = '0; chk_d = '0; to_d = '0;
        end
      ADDR:
        if (rx_vld_q) begin
          to_d = '0; addr_d = {rx_sh_q, addr_q[31:8]}; chk_d = chk_q ^ rx_sh_q;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) st_d = DATA;
        end else tmo = 1'b1;
      DATA:
        if (rx_vld_q) begin
          to_d = '0; data_d = {rx_sh_q, data_q[31:8]}; chk_d = chk_q ^ rx_sh_q;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
`ifdef UART_DL_CHKSUM_EN
            st_d = CHK;
`else
            if (addr_q[1:0] == 2'b00) go_wr = 1'b1;
            else begin start_ack = 1'b1; ack_code = 8'hEE; end
`endif
          end
        end else tmo = 1'b1;
`ifdef UART_DL_CHKSUM_EN
      CHK:
        if (rx_vld_q) begin
          if (rx_sh_q == chk_q && addr_q[1:0] == 2'b00) go_wr = 1'b1;
          else begin start_ack = 1'b1; ack_code = 8'hEE; end
        end else tmo = 1'b1;
`endif
      WRITE:
        if (m_grant_i) begin req_d = 1'b0; start_ack = 1'b1; ack_code = 8'h5A; end
      ACK:
        if (tx_done) begin st_d = HDR; active_d = 1'b0; end
      default: st_d = HDR;
    endcase

    // data_d already carries the final data byte when DATA jumps straight to WRITE
    if (go_wr) begin
      st_d = WRITE; req_d = 1'b1; m_addr_d = addr_q; m_data_d = data_d;
    end
    if (start_ack) begin
      st_d = ACK; tx_busy_d = 1'b1; tx_cnt_d = '0; tx_bit_d = '0;
      tx_sh_d = {1'b1, ack_code, 1'b0}; tx_pin_d = 1'b0;
    end
    if (tmo) begin
      if (to_q == TO_LAST) begin
        st_d = HDR; active_d = 1'b0; to_d = '0; byte_cnt_d = '0;
      end else to_d = to_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_st_q <= RX_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0; rx_vld_q <= 1'b0;
      tx_busy_q <= 1'b0; tx_pin_q <= 1'b1; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '1;
      st_q <= HDR; byte_cnt_q <= '0; addr_q <= '0; data_q <= '0; chk_q <= '0; to_q <= '0;
      active_q <= 1'b0; req_q <= 1'b0; m_addr_q <= '0; m_data_q <= '0;
    end else begin
      rx_s1_q <= rx_s1_d; rx_s2_q <= rx_s2_d; rx_prev_q <= rx_prev_d;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d; rx_vld_q <= rx_vld_d;
      tx_busy_q <= tx_busy_d; tx_pin_q <= tx_pin_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
      st_q <= st_d; byte_cnt_q <= byte_cnt_d; addr_q <= addr_d; data_q <= data_d; chk_q <= chk_d; to_q <= to_d;
      active_q <= active_d; req_q <= req_d; m_addr_q <= m_addr_d; m_data_q <= m_data_d;
    end
  end

  assign uart_tx_pin = tx_pin_q;
  assign m_addr_o    = m_addr_q;
  assign m_data_o    = m_data_q;
  assign m_req_o     = req_q;
  assign m_wr_en_o   = req_q;
  assign dl_active_o = active_q;
endmodule

// File: tb/tb_uart_dl.sv
// Bench for uart_dl: table of packets, random packets against a packet-level model, and corner sequences.
module tb_uart_dl;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int TO_CYC   = 1000;
  localparam int BC       = CLK_FREQ / BAUD;

  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, grant = 1'b1;
  logic tx, req, wr_en, active;
  logic [31:0] m_addr, m_data;

  uart_dl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .uart_rx_pin(rx), .uart_tx_pin(tx),
    .m_addr_o(m_addr), .m_data_o(m_data), .m_req_o(req), .m_wr_en_o(wr_en),
    .m_grant_i(grant), .dl_active_o(active));

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;
  logic [7:0]  ackq[$];
  logic [64:0] wrq[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          corrupt;
    bit          exp_wr;
    logic [7:0]  exp_code;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // completed bus writes, as {wr_en, addr, data}
  always @(negedge clk)
    if (!rst && req && grant) wrq.push_back({wr_en, m_addr, m_data});

  // serial decoder for the acknowledge line
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      if (rst) continue;
      repeat (BC / 2) @(posedge clk);
      if (tx !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        repeat (BC) @(posedge clk);
        b[i] = tx;
      end
      repeat (BC) @(posedge clk);
      if (tx !== 1'b1) b = 8'hXX;
      ackq.push_back(b);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0; repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; repeat (BC) @(negedge clk);
    end
    rx = stop; repeat (BC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, inout logic [7:0] x);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      x ^= b;
      send_byte(b, 1'b1);
    end
  endtask

  task automatic send_pkt(input logic [31:0] a, input logic [31:0] d, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    @(negedge clk);
    send_byte(8'hA5, 1'b1);
    send_word(a, x);
    send_word(d, x);
`ifdef UART_DL_CHKSUM_EN
    send_byte(corrupt ? (x ^ 8'h01) : x, 1'b1);
`else
    if (corrupt) x = 8'h00;
`endif
  endtask

  task automatic wait_ack(input string name, output logic [7:0] code);
    int n;
    n = 0;
    while (ackq.size() == 0 && n < 40 * BC) begin @(negedge clk); n++; end
    if (ackq.size() == 0) begin
      code = 8'hXX;
      n_vec++; n_fail++;
      $display("FAIL %s: no acknowledge byte within %0d cycles", name, 40 * BC);
    end else code = ackq.pop_front();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (active !== 1'b0 && n < 8 * BC) begin @(negedge clk); n++; end
    check({name, "_idle"}, {71'd0, active}, 72'd0);
  endtask

  // packet-level model: write only for an intact checksum and a word-aligned address
  function automatic void model(input logic [31:0] a, input bit corrupt, output bit wr, output logic [7:0] code);
`ifdef UART_DL_CHKSUM_EN
    wr = !corrupt && (a % 4 == 0);
`else
    wr = (a % 4 == 0);
`endif
    code = wr ? 8'h5A : 8'hEE;
  endfunction

  task automatic run_pkt(input string name, input logic [31:0] a, input logic [31:0] d, input bit corrupt,
                         input bit exp_wr, input logic [7:0] exp_code);
    logic [7:0] code;
    ackq.delete(); wrq.delete();
    send_pkt(a, d, corrupt);
    wait_ack(name, code);
    check({name, "_code"}, {64'd0, code}, {64'd0, exp_code});
    wait_idle(name);
    check({name, "_nwr"}, 72'(wrq.size()), 72'(exp_wr));
    if (exp_wr && wrq.size() > 0)
      check({name, "_wr"}, {7'd0, wrq[0]}, {7'd0, 1'b1, a, d});
  endtask

  initial begin
    bit ewr;
    logic [7:0] ecode, code;
    logic [31:0] a, d;
    bit c;
    bit stable;
    int n;

    vecs[0] = '{32'h00001000, 32'hDEADBEEF, 1'b0, 1'b1, 8'h5A};
`ifdef UART_DL_CHKSUM_EN
    vecs[1] = '{32'h00001000, 32'hDEADBEEF, 1'b1, 1'b0, 8'hEE};
`else
    vecs[1] = '{32'h00001000, 32'hDEADBEEF, 1'b1, 1'b1, 8'h5A};
`endif
    vecs[2] = '{32'h00001002, 32'hDEADBEEF, 1'b0, 1'b0, 8'hEE};
    vecs[3] = '{32'h80000004, 32'h12345678, 1'b0, 1'b1, 8'h5A};
    vecs[4] = '{32'h00000003, 32'hA5A5A5A5, 1'b1, 1'b0, 8'hEE};
    vecs[5] = '{32'hFFFFFFFC, 32'h00000000, 1'b0, 1'b1, 8'h5A};

    repeat (3) @(negedge clk);
    check("rst_outputs", {36'd0, tx, req, wr_en, active, m_addr},   {36'd0, 4'b1000, 32'd0});
    check("rst_data",    {40'd0, m_data}, 72'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst", {68'd0, tx, req, wr_en, active}, {68'd0, 4'b1000});

    foreach (vecs[i])
      run_pkt($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].corrupt, vecs[i].exp_wr, vecs[i].exp_code);

    for (int i = 0; i < 12; i++) begin
      a = $urandom; d = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      c = ($urandom_range(0, 3) == 0);
      model(a, c, ewr, ecode);
      run_pkt($sformatf("rnd%0d", i), a, d, c, ewr, ecode);
    end

    // glitched start and a framing-error byte inside a packet are both ignored
    ackq.delete(); wrq.delete();
    @(negedge clk);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    rx = 1'b0; repeat (3) @(negedge clk); rx = 1'b1; repeat (2 * BC) @(negedge clk);
    send_byte(8'h10, 1'b1);
    send_byte(8'h77, 1'b0); repeat (2 * BC) @(negedge clk);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h44, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h11, 1'b1);
`ifdef UART_DL_CHKSUM_EN
    send_byte(8'h10 ^ 8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11, 1'b1);
`endif
    wait_ack("noise", code);
    check("noise_code", {64'd0, code}, {64'd0, 8'h5A});
    wait_idle("noise");
    check("noise_wr", {7'd0, wrq.size() == 1 ? wrq[0] : 65'd0}, {7'd0, 1'b1, 32'h00001000, 32'h11223344});

    // grant held low: request and bus values hold until grant arrives
    ackq.delete(); wrq.delete();
    grant = 1'b0;
    send_pkt(32'h00002000, 32'hCAFEF00D, 1'b0);
    n = 0;
    while (req !== 1'b1 && n < 4 * BC) begin @(negedge clk); n++; end
    stable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req !== 1'b1 || wr_en !== 1'b1 || m_addr !== 32'h00002000 || m_data !== 32'hCAFEF00D || ackq.size() != 0)
        stable = 1'b0;
    end
    check("grant_hold", {71'd0, stable}, 72'd1);
    grant = 1'b1;
    wait_ack("grant", code);
    check("grant_code", {64'd0, code}, {64'd0, 8'h5A});
    wait_idle("grant");
    check("grant_nwr", 72'(wrq.size()), 72'd1);

    // partial packet then silence: parser abandons it without a reply
    ackq.delete(); wrq.delete();
    @(negedge clk);
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    repeat (TO_CYC + 4 * BC) @(negedge clk);
    check("timeout_state", {70'd0, active, req}, 72'd0);
    check("timeout_noack", 72'(ackq.size() + wrq.size()), 72'd0);
    run_pkt("after_to", 32'h00003000, 32'h0BADF00D, 1'b0, 1'b1, 8'h5A);

    // reset in the middle of WRITE aborts with no acknowledge
    ackq.delete(); wrq.delete();
    grant = 1'b0;
    send_pkt(32'h00004000, 32'h55AA55AA, 1'b0);
    n = 0;
    while (req !== 1'b1 && n < 4 * BC) begin @(negedge clk); n++; end
    check("rst_wr_req", {71'd0, req}, 72'd1);
    rst = 1'b1; #1;
    check("rst_wr_abort", {36'd0, tx, req, wr_en, active, m_addr}, {36'd0, 4'b1000, 32'd0});
    @(negedge clk); rst = 1'b0; grant = 1'b1;
    repeat (40 * BC) @(negedge clk);
    check("rst_wr_quiet", 72'(ackq.size() + wrq.size()), 72'd0);
    run_pkt("after_rst", 32'h00005000, 32'h01234567, 1'b0, 1'b1, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
